// File: rtl/grid_piece_writer.sv
// Write/check port of the 12x20 grid: CLEAR (240 writes), STAMP/ERASE/CHECK of a 4x4 mask.
// One cell access per granted cycle; reads add one RD_WAIT cycle; stalls while mem_grant is low.
module grid_piece_writer #(
    parameter int         GRID_COLS   = 12,
    parameter int         GRID_ROWS   = 20,
    parameter logic [7:0] BORDER_CODE = 8'd8
) (
    input  logic        px_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_mask,
    input  logic [4:0]  cmd_row,
    input  logic [4:0]  cmd_col,
    input  logic [3:0]  cmd_type,
    input  logic        mem_grant,
    output logic [7:0]  grid_addr,
    output logic [7:0]  grid_wdata,
    output logic        grid_we,
    input  logic [7:0]  grid_rdata,
    output logic        done,
    output logic        collision
);

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_STAMP = 2'd1,
        OP_ERASE = 2'd2,
        OP_CHECK = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLR     = 3'd1,
        S_SCAN    = 3'd2,
        S_RD_WAIT = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [15:0] mask;
        logic [4:0]  row;
        logic [4:0]  col;
        logic [3:0]  ptype;
    } cmd_t;

    localparam logic [5:0] LAST_ROW6    = 6'(GRID_ROWS - 1);
    localparam logic [5:0] LAST_COL6    = 6'(GRID_COLS - 1);
    localparam logic [4:0] LAST_CLR_ROW = 5'(GRID_ROWS - 1);
    localparam logic [3:0] LAST_CLR_COL = 4'(GRID_COLS - 1);
    localparam logic [7:0] LAST_CELL    = 8'(GRID_COLS * GRID_ROWS - 1);
    localparam logic [7:0] COLS8        = 8'(GRID_COLS);
    localparam logic [7:0] CODE_MASK    = 8'h0F;

    state_e     state;
    state_e     state_nxt;
    cmd_t       cur;
    logic [3:0] idx;
    logic [7:0] cnt;
    logic [4:0] clr_row;
    logic [3:0] clr_col;

    logic       accept;
    logic [5:0] scan_row;
    logic [5:0] scan_col;
    logic       in_range;
    logic       bit_set;
    logic       is_check;
    logic [7:0] scan_addr;
    logic       scan_adv;
    logic       scan_rd;
    logic       clr_wr;
    logic       clr_border;
    logic       rd_hit;

    // Box coordinates are widened to 6 bits so anchors near the edge cannot wrap back into range.
    assign scan_row   = {1'b0, cur.row} + {4'b0, idx[3:2]};
    assign scan_col   = {1'b0, cur.col} + {4'b0, idx[1:0]};
    assign in_range   = (scan_row <= LAST_ROW6) && (scan_col <= LAST_COL6);
    assign bit_set    = cur.mask[idx];
    assign is_check   = (cur.op == OP_CHECK);
    assign scan_addr  = COLS8 * {3'b0, scan_row[4:0]} + {2'b0, scan_col};

    assign accept     = cmd_valid && cmd_ready;
    assign scan_adv   = (state == S_SCAN) &&
                        (!bit_set || !in_range || (mem_grant && !is_check));
    assign scan_rd    = (state == S_SCAN) && bit_set && in_range && mem_grant && is_check;
    assign clr_wr     = (state == S_CLR) && mem_grant;
    assign clr_border = (clr_col == 4'd0) || (clr_col == LAST_CLR_COL) ||
                        (clr_row == LAST_CLR_ROW);
    assign rd_hit     = |(grid_rdata & CODE_MASK);

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (op_e'(cmd_op) == OP_CLEAR) ? S_CLR : S_SCAN;
                end
            end
            S_CLR: begin
                if (clr_wr && (cnt == LAST_CELL)) begin
                    state_nxt = S_DONE;
                end
            end
            S_SCAN: begin
                if (scan_rd) begin
                    state_nxt = S_RD_WAIT;
                end else if (scan_adv && (idx == 4'd15)) begin
                    state_nxt = S_DONE;
                end
            end
            S_RD_WAIT: begin
                state_nxt = (idx == 4'd15) ? S_DONE : S_SCAN;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        done       = 1'b0;
        grid_we    = 1'b0;
        grid_addr  = 8'd0;
        grid_wdata = 8'd0;
        case (state)
            S_IDLE: begin
                cmd_ready = !reset;
            end
            S_CLR: begin
                grid_addr  = cnt;
                grid_we    = mem_grant;
                grid_wdata = clr_border ? BORDER_CODE : 8'd0;
            end
            S_SCAN: begin
                if (bit_set && in_range) begin
                    grid_addr  = scan_addr;
                    grid_we    = mem_grant && !is_check;
                    grid_wdata = (cur.op == OP_STAMP) ? {4'b0, cur.ptype} : 8'd0;
                end
            end
            S_RD_WAIT: begin
                // Keep the read address stable while the data returns.
                if (bit_set && in_range) begin
                    grid_addr = scan_addr;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            cur       <= '0;
            idx       <= 4'd0;
            cnt       <= 8'd0;
            clr_row   <= 5'd0;
            clr_col   <= 4'd0;
            collision <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cur.op    <= op_e'(cmd_op);
                        cur.mask  <= cmd_mask;
                        cur.row   <= cmd_row;
                        cur.col   <= cmd_col;
                        cur.ptype <= cmd_type;
                        idx       <= 4'd0;
                        cnt       <= 8'd0;
                        clr_row   <= 5'd0;
                        clr_col   <= 4'd0;
                        collision <= 1'b0;
                    end
                end
                S_CLR: begin
                    if (clr_wr) begin
                        cnt <= cnt + 8'd1;
                        if (clr_col == LAST_CLR_COL) begin
                            clr_col <= 4'd0;
                            clr_row <= clr_row + 5'd1;
                        end else begin
                            clr_col <= clr_col + 4'd1;
                        end
                    end
                end
                S_SCAN: begin
                    if (scan_adv) begin
                        idx <= idx + 4'd1;
                        if (bit_set && !in_range) begin
                            collision <= 1'b1;
                        end
                    end
                end
                S_RD_WAIT: begin
                    idx <= idx + 4'd1;
                    if (rd_hit) begin
                        collision <= 1'b1;
                    end
                end
                default: begin
                    idx <= idx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_piece_writer.sv
// Directed bench for grid_piece_writer with a behavioural grid memory and write log.
module tb_grid_piece_writer;

    logic        px_clk = 1'b0;
    logic        reset  = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_mask = 16'd0;
    logic [4:0]  cmd_row = 5'd0;
    logic [4:0]  cmd_col = 5'd0;
    logic [3:0]  cmd_type = 4'd0;
    logic        mem_grant = 1'b1;
    logic [7:0]  grid_addr;
    logic [7:0]  grid_wdata;
    logic        grid_we;
    logic [7:0]  grid_rdata = 8'd0;
    logic        done;
    logic        collision;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [256];
    logic [15:0] wlog [$];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = 8'd0;
    logic [7:0]  pre_val = 8'd0;

    always #5 px_clk = ~px_clk;

    grid_piece_writer dut (
        .px_clk     (px_clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_mask   (cmd_mask),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .cmd_type   (cmd_type),
        .mem_grant  (mem_grant),
        .grid_addr  (grid_addr),
        .grid_wdata (grid_wdata),
        .grid_we    (grid_we),
        .grid_rdata (grid_rdata),
        .done       (done),
        .collision  (collision)
    );

    always @(posedge px_clk) begin
        if (grid_we) begin
            mem[grid_addr] <= grid_wdata;
            wlog.push_back({grid_addr, grid_wdata});
        end else if (pre_en) begin
            mem[pre_addr] <= pre_val;
        end
        grid_rdata <= mem[grid_addr];
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] mask;
        logic [4:0]  row;
        logic [4:0]  col;
        logic [3:0]  ptype;
        logic        pre;
        logic [7:0]  paddr;
        logic [7:0]  pval;
        int          drop;
        int          nwr;
        logic [31:0] addrs;
        logic [7:0]  wdat;
        logic        coll;
        int          cycles;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [15:0] mask,
                                input logic [4:0] row, input logic [4:0] col,
                                input logic [3:0] ptype, input logic pre,
                                input logic [7:0] paddr, input logic [7:0] pval,
                                input int drop, input int nwr, input logic [31:0] addrs,
                                input logic [7:0] wdat, input logic coll, input int cycles);
        vec_t v;
        v.op = op; v.mask = mask; v.row = row; v.col = col; v.ptype = ptype;
        v.pre = pre; v.paddr = paddr; v.pval = pval; v.drop = drop; v.nwr = nwr;
        v.addrs = addrs; v.wdat = wdat; v.coll = coll; v.cycles = cycles;
        return v;
    endfunction

    task automatic accept_cmd(input logic [1:0] op, input logic [15:0] mask,
                              input logic [4:0] row, input logic [4:0] col,
                              input logic [3:0] ptype, input string tag);
        @(negedge px_clk);
        chk({tag, "_ready_before"}, cmd_ready, 1'b1);
        cmd_op = op; cmd_mask = mask; cmd_row = row; cmd_col = col; cmd_type = ptype;
        cmd_valid = 1'b1;
        @(posedge px_clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc = 0;
        int dropn = 0;
        int we_in_drop = 0;
        int ready_bad = 0;
        int held_sz = -1;
        logic got = 1'b0;
        logic coll_at_done = 1'b0;
        if (v.pre) begin
            @(negedge px_clk);
            pre_addr = v.paddr; pre_val = v.pval; pre_en = 1'b1;
            @(negedge px_clk);
            pre_en = 1'b0;
        end
        wlog.delete();
        accept_cmd(v.op, v.mask, v.row, v.col, v.ptype, tag);
        while (!got && cyc < 1000) begin
            @(negedge px_clk);
            cmd_valid = 1'b0;
            cyc++;
            if (dropn < v.drop && wlog.size() >= 1) begin
                mem_grant = 1'b0;
                dropn++;
                #1;
                if (grid_we) we_in_drop++;
            end else begin
                if (v.drop > 0 && dropn == v.drop && held_sz < 0) held_sz = wlog.size();
                mem_grant = 1'b1;
                #1;
            end
            if (done) begin
                got = 1'b1;
                coll_at_done = collision;
            end else if (cmd_ready) begin
                ready_bad++;
            end
        end
        mem_grant = 1'b1;
        chk({tag, "_done_seen"}, got, 1'b1);
        if (v.cycles != 0) chk({tag, "_cycles"}, cyc, v.cycles);
        chk({tag, "_coll"}, coll_at_done, v.coll);
        chk({tag, "_nwr"}, wlog.size(), v.nwr);
        chk({tag, "_ready_busy"}, ready_bad, 0);
        if (v.drop > 0) begin
            chk({tag, "_we_in_drop"}, we_in_drop, 0);
            chk({tag, "_held_writes"}, held_sz, 1);
        end
        for (int i = 0; i < v.nwr && i < wlog.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), wlog[i],
                {v.addrs[8*(3-i) +: 8], v.wdat});
        end
        @(negedge px_clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_ready_after"}, cmd_ready, 1'b1);
        chk({tag, "_coll_hold"}, collision, v.coll);
    endtask

    initial begin
        int cyc;
        int errs;
        int dn;
        logic got;
        logic [7:0] ex;

        tbl[0]  = mk(2'd1, 16'h0072, 5'd5,  5'd4,  4'd3,  1'b0, 8'd0,  8'd0, 0, 4, {8'd65, 8'd76, 8'd77, 8'd78}, 8'd3,  1'b0, 17);
        tbl[1]  = mk(2'd2, 16'h0072, 5'd5,  5'd4,  4'd3,  1'b0, 8'd0,  8'd0, 0, 4, {8'd65, 8'd76, 8'd77, 8'd78}, 8'd0,  1'b0, 17);
        tbl[2]  = mk(2'd3, 16'h0072, 5'd5,  5'd4,  4'd0,  1'b0, 8'd0,  8'd0, 0, 0, 32'd0, 8'd0,  1'b0, 21);
        tbl[3]  = mk(2'd3, 16'h0072, 5'd5,  5'd4,  4'd0,  1'b1, 8'd77, 8'd2, 0, 0, 32'd0, 8'd0,  1'b1, 21);
        tbl[4]  = mk(2'd1, 16'h000F, 5'd2,  5'd10, 4'd5,  1'b0, 8'd0,  8'd0, 0, 2, {8'd34, 8'd35, 16'd0}, 8'd5, 1'b1, 17);
        tbl[5]  = mk(2'd1, 16'h0000, 5'd5,  5'd4,  4'd3,  1'b0, 8'd0,  8'd0, 0, 0, 32'd0, 8'd0,  1'b0, 17);
        tbl[6]  = mk(2'd3, 16'h0001, 5'd19, 5'd0,  4'd0,  1'b0, 8'd0,  8'd0, 0, 0, 32'd0, 8'd0,  1'b1, 18);
        tbl[7]  = mk(2'd1, 16'h0001, 5'd0,  5'd5,  4'hC,  1'b0, 8'd0,  8'd0, 0, 1, {8'd5, 24'd0}, 8'h0C, 1'b0, 17);
        tbl[8]  = mk(2'd1, 16'h0072, 5'd5,  5'd4,  4'd3,  1'b0, 8'd0,  8'd0, 5, 4, {8'd65, 8'd76, 8'd77, 8'd78}, 8'd3,  1'b0, 20);
        tbl[9]  = mk(2'd3, 16'h0072, 5'd5,  5'd4,  4'd0,  1'b0, 8'd0,  8'd0, 0, 0, 32'd0, 8'd0,  1'b1, 21);
        tbl[10] = mk(2'd3, 16'h1000, 5'd19, 5'd0,  4'd0,  1'b0, 8'd0,  8'd0, 0, 0, 32'd0, 8'd0,  1'b1, 17);

        repeat (3) @(negedge px_clk);
        chk("rst_we", grid_we, 1'b0);
        chk("rst_addr", grid_addr, 8'd0);
        chk("rst_wdata", grid_wdata, 8'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_coll", collision, 1'b0);
        reset = 1'b0;
        @(negedge px_clk);
        chk("rst_ready", cmd_ready, 1'b1);

        // Full CLEAR with the grant held high.
        wlog.delete();
        accept_cmd(2'd0, 16'd0, 5'd0, 5'd0, 4'd0, "clr");
        cyc = 0; got = 1'b0; errs = 0;
        while (!got && cyc < 1000) begin
            @(negedge px_clk);
            cmd_valid = 1'b0;
            cyc++;
            if (done) got = 1'b1;
            else if (cmd_ready) errs++;
        end
        chk("clr_done_seen", got, 1'b1);
        chk("clr_cycles", cyc, 241);
        chk("clr_ready_busy", errs, 0);
        chk("clr_nwr", wlog.size(), 240);
        errs = 0;
        for (int i = 0; i < 240 && i < wlog.size(); i++) begin
            ex = ((i % 12 == 0) || (i % 12 == 11) || (i / 12 == 19)) ? 8'd8 : 8'd0;
            if (wlog[i] !== {8'(i), ex}) errs++;
        end
        chk("clr_log_errs", errs, 0);
        chk("clr_addr0", mem[0], 8'd8);
        chk("clr_addr13", mem[13], 8'd0);
        chk("clr_addr23", mem[23], 8'd8);
        errs = 0;
        for (int a = 228; a < 240; a++) if (mem[a] !== 8'd8) errs++;
        chk("clr_bottom_row", errs, 0);
        @(negedge px_clk);
        chk("clr_done_pulse", done, 1'b0);

        for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("v%0d", i));

        // Reset lands after the 100th CLEAR write.
        wlog.delete();
        accept_cmd(2'd0, 16'd0, 5'd0, 5'd0, 4'd0, "rclr");
        cyc = 0;
        while (wlog.size() < 100 && cyc < 500) begin
            @(negedge px_clk);
            cmd_valid = 1'b0;
            cyc++;
        end
        chk("rclr_reach100", wlog.size(), 100);
        reset = 1'b1;
        #1;
        chk("rclr_we_now", grid_we, 1'b0);
        chk("rclr_addr_now", grid_addr, 8'd0);
        dn = 0;
        repeat (3) begin
            @(negedge px_clk);
            if (done) dn++;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge px_clk);
            if (done) dn++;
        end
        chk("rclr_no_done", dn, 0);
        chk("rclr_writes_stopped", wlog.size(), 100);
        chk("rclr_ready", cmd_ready, 1'b1);
        chk("rclr_coll", collision, 1'b0);
        run_vec(mk(2'd1, 16'h0001, 5'd0, 5'd1, 4'd7, 1'b0, 8'd0, 8'd0, 0, 1,
                   {8'd1, 24'd0}, 8'd7, 1'b0, 17), "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grid_piece_writer.md
Name: grid_piece_writer

Overview:
- Write/check side of the Tetris grid memory (12 cols x 20 rows, 8-bit cells, low nibble = cell code); the video path only reads this memory.
- Accepts one command at a time from game control:
  - CLEAR: initialise the grid with borders.
  - STAMP: write a piece.
  - ERASE: remove a piece.
  - CHECK: collision test.
- Each piece is given as a 4x4 occupancy mask anchored at a grid row/col.
- Drives the grid memory port only when the arbiter grants it (mem_grant).

Parameters:
- GRID_COLS, 12, grid width; cell address = GRID_COLS*row + col.
- GRID_ROWS, 20, grid height; total cells = 240.
- BORDER_CODE, 8, code written to border cells by CLEAR.

Ports:
- px_clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle, command can be accepted
- cmd_op  in  2  0=CLEAR, 1=STAMP, 2=ERASE, 3=CHECK
- cmd_mask  in  16  bit i occupies box cell (dr=i[3:2], dc=i[1:0])
- cmd_row  in  5  anchor row of mask box (unsigned)
- cmd_col  in  5  anchor col of mask box (unsigned)
- cmd_type  in  4  piece code for STAMP
- mem_grant  in  1  grid port available this cycle
- grid_addr  out  8  cell address
- grid_wdata  out  8  write data
- grid_we  out  1  write strobe
- grid_rdata  in  8  read data, valid 1 cycle after address presented
- done  out  1  one-cycle pulse, command complete
- collision  out  1  result of last STAMP/ERASE/CHECK

Behaviour:
- Reset (asynchronous, any time, including mid-command):
  - state=IDLE; grid_we=0, grid_addr=0, grid_wdata=0, done=0, collision=0.
  - Command in progress is aborted; no further writes.
  - cmd_ready=1 from the first clock after reset deasserts.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op/mask/row/col/type, set idx=0 and cnt=0, and clear collision.
  - cmd_ready=0 from the next cycle until return to IDLE.
  - Next state: CLR if op=0, else SCAN.
- CLR:
  - Each cycle with mem_grant=1: grid_we=1, grid_addr=cnt.
  - grid_wdata=BORDER_CODE if cell col==0, col==11 or row==19; else 0.
  - cnt increments after each write.
  - mem_grant=0: grid_we=0, cnt held.
  - After the write of cnt=239, go to DONE. Exactly 240 writes in ascending order.
- SCAN, per idx 0..15: r=cmd_row+idx[3:2], c=cmd_col+idx[1:0], computed at 6 bits (no wrap).
  - mask[idx]=0: no memory access; idx++ in 1 cycle, grant not needed.
  - mask[idx]=1 and (r>19 or c>11): collision<=1, no access, idx++.
  - mask[idx]=1 in range, STAMP/ERASE:
    - Wait until mem_grant=1.
    - Then grid_we=1, grid_addr=12r+c, grid_wdata={4'b0,cmd_type} for STAMP or 0 for ERASE; idx++.
  - mask[idx]=1 in range, CHECK:
    - Wait until mem_grant=1.
    - Then present grid_addr with grid_we=0 and go to RD_WAIT.
- RD_WAIT:
  - Sample grid_rdata; if grid_rdata[3:0]!=0, set collision<=1.
  - idx++, return to SCAN. mem_grant is ignored here.
- SCAN exit: after idx=15 is processed, go to DONE. All 16 bits are always scanned; no early exit.
- Outputs: grid_addr, grid_wdata and grid_we are combinational from state, counters and mem_grant. grid_we is never asserted in IDLE, RD_WAIT or DONE.
- DONE:
  - done=1 for one cycle, then IDLE.
  - collision holds its value until the next command is accepted.
- Ordering: no write reordering; writes and reads are issued in idx or cnt order.
- Unsupported inputs: cmd_type values above 8 are written as-is. STAMP with mask=0 completes in 17 cycles with no writes.

Test Plan:
- Reset, then CLEAR with mem_grant=1 -> 240 writes:
  - addr0=8, addr13=0, addr23=8, addrs 228..239 all 8.
  - done pulses the cycle after the last write; cmd_ready=0 throughout.
- STAMP mask=0x0072, type=3, row=5, col=4, mem_grant=1:
  - Writes addr 65, 76, 77, 78 in that order, data=3.
  - collision=0, done pulses once.
- Preload addr77=2, then CHECK mask=0x0072, row=5, col=4:
  - 4 reads (addr 65, 76, 77, 78), grid_we never asserted.
  - collision=1 at done.
- STAMP mask=0x000F, row=2, col=10, type=5 -> writes only addr 34 and 35; collision=1.
- During STAMP 0x0072, drop mem_grant for 5 cycles before the 2nd write:
  - grid_we=0 for those cycles, idx held.
  - Writes resume at addr 76; exactly 4 writes total.
- Assert reset after 100 CLEAR writes:
  - grid_we=0 immediately, done never pulses.
  - cmd_ready=1 after release; a new STAMP is accepted normally.
